pipelined_adder_tree: RTL and testbench
=======================================

PIPELINED_ADDER_TREE -- requirements
Module: pipelined_adder_tree

Interface
REQ-001 The block SHALL have the parameter N, default 8: number of input operands, any integer >= 1.
REQ-002 The block SHALL have the parameter W, default 16: width of each operand in bits.
REQ-003 The block SHALL have the parameter SIGNED, default 0: 1 means two's-complement operands, 0 means unsigned.
REQ-004 The block SHALL have the parameter OUTW, default W+$clog2(N) (W when N=1): output width, any value from 1 to W+$clog2(N).
REQ-005 The block SHALL have the parameter SAT, default 0: 1 clamps out-of-range sums, 0 keeps the low OUTW bits.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset, and SHALL have exactly these ports:
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  an operand vector is presented
- in_ready  output  1  the block can accept a vector this cycle
- in  input  N*W  operand k occupies bits [W*k+W-1 : W*k]
- out_valid  output  1  out holds a result
- out_ready  input  1  the consumer accepts the result this cycle
- out  output  OUTW  the sum
- ovf  output  1  the sum for this result did not fit in OUTW bits; qualified by out_valid

Function
REQ-007 The tree SHALL have L = max(1, $clog2(N)) register stages, one per reduction level.
REQ-008 Each stage SHALL add adjacent pairs from the previous level. An odd leftover element SHALL pass through unchanged, so a non-power-of-2 N needs no zero padding at the input.
REQ-009 Internal sums SHALL be full precision, W+$clog2(N) bits. Operands SHALL be sign-extended when SIGNED=1 and zero-extended when SIGNED=0. Internal arithmetic SHALL never wrap.
REQ-010 An input transfer SHALL occur when in_valid and in_ready are both 1. An output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-011 Internal signal advance SHALL be defined as (!out_valid || out_ready). When advance=1, all stages and their valid bits SHALL shift forward by one. When advance=0, all stages SHALL hold.
REQ-012 in_ready SHALL equal advance, and SHALL be combinational from out_ready and out_valid only.
REQ-013 Stage 1's valid bit SHALL load (in_valid && in_ready). Bubbles SHALL propagate as invalid stages.
REQ-014 Latency with out_ready held at 1 SHALL be exactly L cycles: a vector accepted in cycle t produces out_valid=1 with its sum in cycle t+L.
REQ-015 Throughput with out_ready held at 1 SHALL be one vector per cycle.
REQ-016 Results SHALL leave in acceptance order. No result SHALL be dropped or duplicated.
REQ-017 While out_valid=1 and out_ready=0, out and ovf SHALL be held stable.
REQ-018 Final narrowing happens in the last stage and SHALL follow these rules.
- Define range: [-2^(OUTW-1), 2^(OUTW-1)-1] when SIGNED=1; [0, 2^OUTW-1] when SIGNED=0.
- ovf SHALL be 1 when the full-precision sum lies outside that range.
- SAT=1: out SHALL be clamped to the nearest bound.
- SAT=0: out SHALL be the low OUTW bits of the sum.
REQ-019 When OUTW = W+$clog2(N), ovf SHALL be constantly 0.
REQ-020 An in_valid=1 with in_ready=0 SHALL NOT be captured. The producer holds the vector; the block SHALL NOT require this for correctness.
REQ-021 Output signals SHALL NOT depend combinationally on in or in_valid.

Reset
REQ-022 While rst=1 at a rising clk edge, every stage valid bit SHALL clear to 0.
REQ-023 After that edge, out_valid SHALL be 0, out SHALL be 0 and ovf SHALL be 0.
REQ-024 While rst=1, in_ready SHALL be 1 (it is not forced low). No input transfer SHALL be captured in a cycle where rst=1.
REQ-025 A reset asserted mid-operation SHALL discard all in-flight results. No result accepted before the reset SHALL appear afterwards.
REQ-026 Stage data registers other than out need not be reset.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Unsigned, N=8, W=16, defaults, all operands 0xFFFF, out_ready=1 -> out=0x7FFF8, ovf=0, exactly 3 cycles after acceptance.
- N=5, W=16, operands 1,2,3,4,5, then back-to-back vector 10,20,30,40,50 -> out=15 then 150 on consecutive cycles, latency 3.
- Signed, N=4, W=8, OUTW=8, SAT=1: {0x7F,0x7F,0x01,0x00} -> out=0x7F, ovf=1. Then {0x80,0x80,0x80,0x80} -> out=0x80, ovf=1. Then {0x10,0xF0,0x05,0x00} -> out=0x05, ovf=0.
- Same signed cases with SAT=0 -> out=0xFF, ovf=1; then out=0x00, ovf=1.
- Backpressure: stream of 6 vectors, out_ready=0 for cycles 4-7 -> in_ready=0 exactly while out_valid=1 and out_ready=0; all 6 sums emerge in order; out stable during the stall.
- Reset mid-stream: assert rst for 1 cycle with 2 vectors in flight -> out_valid=0 the next cycle; neither in-flight sum ever appears; the next accepted vector emerges with latency L.

Source files
------------

// File: rtl/pipelined_adder_tree_if.sv
// Valid/ready bundle for the pipelined adder tree.
// master drives operands and out_ready; slave is the tree itself.
//
// Signals:
//   in_valid  / in_ready  : operand vector handshake
//   in        : N operands, operand k at bits [W*k +: W]
//   out_valid / out_ready : result handshake
//   out       : narrowed sum (OUTW bits)
//   ovf       : sum did not fit in OUTW bits
interface pipelined_adder_tree_if #(
    parameter int N    = 8,
    parameter int W    = 16,
    parameter int OUTW = W + $clog2(N)
);
    logic            in_valid;
    logic            in_ready;
    logic [N*W-1:0]  in;
    logic            out_valid;
    logic            out_ready;
    logic [OUTW-1:0] out;
    logic            ovf;

    modport master (
        output in_valid,
        input  in_ready,
        output in,
        input  out_valid,
        output out_ready,
        input  out,
        input  ovf
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in,
        output out_valid,
        input  out_ready,
        output out,
        output ovf
    );
endinterface

// File: rtl/pipelined_adder_tree.sv
// Pipelined binary adder tree: one register stage per reduction level,
// full-precision internal sums, optional saturation on the final narrowing.
//
// Ports:
//   clk : clock, all state changes on rising edge
//   rst : synchronous active-high reset (clears valid bits and out/ovf)
//   bus : pipelined_adder_tree_if.slave
//         in_valid/in_ready/in, out_valid/out_ready/out/ovf
module pipelined_adder_tree #(
    parameter int N      = 8,
    parameter int W      = 16,
    parameter int SIGNED = 0,
    parameter int OUTW   = W + $clog2(N),
    parameter int SAT    = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    pipelined_adder_tree_if.slave bus
);

    localparam int FW = W + $clog2(N);
    localparam int L  = (N > 1) ? $clog2(N) : 1;

    // Number of live elements after `lvl` reduction levels.
    function automatic int lvl_cnt(input int lvl);
        int c;
        c = N;
        for (int i = 0; i < lvl; i++) begin
            c = (c + 1) / 2;
        end
        return c;
    endfunction

    logic          adv;
    logic [FW-1:0] lvl_in [L][N];
    logic [FW-1:0] sum    [L][N];
    logic [FW-1:0] data_d [L][N];
    logic [FW-1:0] data_q [L][N];
    logic [L-1:0]  vld_d;
    logic [L-1:0]  vld_q;

    logic [FW-1:0]   tree_sum;
    logic [OUTW-1:0] nar_out;
    logic            nar_ovf;
    logic [OUTW-1:0] out_d;
    logic [OUTW-1:0] out_q;
    logic            ovf_d;
    logic            ovf_q;

    // The whole pipe moves as one unit; a stalled output freezes every stage.
    assign adv          = !vld_q[L-1] || bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin : level_inputs
        for (int s = 0; s < L; s++) begin
            for (int k = 0; k < N; k++) begin
                lvl_in[s][k] = '0;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (SIGNED != 0) begin
                lvl_in[0][k] = FW'($signed(bus.in[W*k +: W]));
            end else begin
                lvl_in[0][k] = FW'(bus.in[W*k +: W]);
            end
        end
        for (int s = 1; s < L; s++) begin
            for (int k = 0; k < N; k++) begin
                lvl_in[s][k] = data_q[s-1][k];
            end
        end
    end

    // Pairwise reduction; an odd leftover element passes through unchanged.
    always_comb begin : reduce
        int ia;
        int ib;
        for (int s = 0; s < L; s++) begin
            for (int j = 0; j < N; j++) begin
                ia = (2 * j < N) ? 2 * j : N - 1;
                ib = (2 * j + 1 < N) ? 2 * j + 1 : N - 1;
                sum[s][j] = '0;
                if (j < lvl_cnt(s + 1)) begin
                    if (2 * j + 1 < lvl_cnt(s)) begin
                        sum[s][j] = lvl_in[s][ia] + lvl_in[s][ib];
                    end else begin
                        sum[s][j] = lvl_in[s][ia];
                    end
                end
            end
        end
    end

    assign tree_sum = sum[L-1][0];

    generate
        if (OUTW == FW) begin : g_full
            assign nar_out = tree_sum;
            assign nar_ovf = 1'b0;
        end else if (SIGNED != 0) begin : g_signed
            logic [FW-OUTW:0] hi;
            logic [OUTW-1:0]  smin;
            // In range only when every dropped bit repeats the new sign bit.
            assign hi      = tree_sum[FW-1:OUTW-1];
            assign nar_ovf = !((&hi) || !(|hi));
            always_comb begin
                smin = '0;
                smin[OUTW-1] = 1'b1;
            end
            assign nar_out = (SAT != 0 && nar_ovf)
                           ? (tree_sum[FW-1] ? smin : ~smin)
                           : tree_sum[OUTW-1:0];
        end else begin : g_unsigned
            logic [FW-OUTW-1:0] hi;
            assign hi      = tree_sum[FW-1:OUTW];
            assign nar_ovf = |hi;
            assign nar_out = (SAT != 0 && nar_ovf)
                           ? {OUTW{1'b1}}
                           : tree_sum[OUTW-1:0];
        end
    endgenerate

    always_comb begin : advance
        vld_d = vld_q;
        out_d = out_q;
        ovf_d = ovf_q;
        for (int s = 0; s < L; s++) begin
            for (int j = 0; j < N; j++) begin
                data_d[s][j] = data_q[s][j];
            end
        end
        // The last level lives in out_q, not in data_q.
        for (int j = 0; j < N; j++) begin
            data_d[L-1][j] = '0;
        end
        if (adv) begin
            vld_d[0] = bus.in_valid;
            for (int s = 1; s < L; s++) begin
                vld_d[s] = vld_q[s-1];
            end
            for (int s = 0; s < L - 1; s++) begin
                for (int j = 0; j < N; j++) begin
                    data_d[s][j] = sum[s][j];
                end
            end
            out_d = nar_out;
            ovf_d = nar_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            out_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            out_q <= out_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < L; s++) begin
            for (int j = 0; j < N; j++) begin
                data_q[s][j] <= data_d[s][j];
            end
        end
    end

    assign bus.out_valid = vld_q[L-1];
    assign bus.out       = out_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed bench for pipelined_adder_tree: four configurations,
// streaming tables, backpressure and mid-stream reset.
module tb_pipelined_adder_tree;

    logic clk = 1'b0;
    logic rst;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    pipelined_adder_tree_if #(.N(8), .W(16)) a_if ();
    pipelined_adder_tree_if #(.N(5), .W(16)) b_if ();
    pipelined_adder_tree_if #(.N(4), .W(8), .OUTW(8)) c_if ();
    pipelined_adder_tree_if #(.N(4), .W(8), .OUTW(8)) d_if ();

    pipelined_adder_tree #(.N(8), .W(16)) u_a (
        .clk(clk), .rst(rst), .bus(a_if)
    );
    pipelined_adder_tree #(.N(5), .W(16)) u_b (
        .clk(clk), .rst(rst), .bus(b_if)
    );
    pipelined_adder_tree #(
        .N(4), .W(8), .SIGNED(1), .OUTW(8), .SAT(1)
    ) u_c (
        .clk(clk), .rst(rst), .bus(c_if)
    );
    pipelined_adder_tree #(
        .N(4), .W(8), .SIGNED(1), .OUTW(8), .SAT(0)
    ) u_d (
        .clk(clk), .rst(rst), .bus(d_if)
    );

    typedef struct {
        logic [127:0] in;
        logic [18:0]  out;
    } a_vec_t;

    typedef struct {
        logic [31:0] in;
        logic [7:0]  sat;
        logic [7:0]  wrap;
        logic        ovf;
    } s_vec_t;

    a_vec_t      a_tab [5];
    s_vec_t      s_tab [7];
    logic [18:0] bp_exp [6];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcv;

        a_tab[0] = '{{8{16'hFFFF}}, 19'h7FFF8};
        a_tab[1] = '{128'h0, 19'h0};
        a_tab[2] = '{{16'd8, 16'd7, 16'd6, 16'd5,
                      16'd4, 16'd3, 16'd2, 16'd1}, 19'd36};
        a_tab[3] = '{{112'h0, 16'hFFFF}, 19'h0FFFF};
        a_tab[4] = '{{8{16'h8000}}, 19'h40000};

        s_tab[0] = '{32'h00017F7F, 8'h7F, 8'hFF, 1'b1};
        s_tab[1] = '{32'h80808080, 8'h80, 8'h00, 1'b1};
        s_tab[2] = '{32'h0005F010, 8'h05, 8'h05, 1'b0};
        s_tab[3] = '{32'h00000080, 8'h80, 8'h80, 1'b0};
        s_tab[4] = '{32'h0000017F, 8'h7F, 8'h80, 1'b1};
        s_tab[5] = '{32'h000081FF, 8'h80, 8'h80, 1'b0};
        s_tab[6] = '{32'h000080FF, 8'h80, 8'h7F, 1'b1};

        bp_exp[0] = 19'd28;
        bp_exp[1] = 19'd2076;
        bp_exp[2] = 19'd4124;
        bp_exp[3] = 19'd6172;
        bp_exp[4] = 19'd8220;
        bp_exp[5] = 19'd10268;

        rst = 1'b1;
        a_if.in_valid = 1'b0; a_if.in = '0; a_if.out_ready = 1'b1;
        b_if.in_valid = 1'b0; b_if.in = '0; b_if.out_ready = 1'b1;
        c_if.in_valid = 1'b0; c_if.in = '0; c_if.out_ready = 1'b1;
        d_if.in_valid = 1'b0; d_if.in = '0; d_if.out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 64'(a_if.in_ready), 64'd1);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_a_valid", 64'(a_if.out_valid), 64'd0);
        chk("rst_a_out", 64'(a_if.out), 64'd0);
        chk("rst_a_ovf", 64'(a_if.ovf), 64'd0);
        chk("rst_b_valid", 64'(b_if.out_valid), 64'd0);
        chk("rst_c_valid", 64'(c_if.out_valid), 64'd0);
        chk("rst_c_out", 64'(c_if.out), 64'd0);
        chk("rst_d_ovf", 64'(d_if.ovf), 64'd0);
        chk("rst_d_ready", 64'(d_if.in_ready), 64'd1);

        // Unsigned N=8: back-to-back stream, latency 3.
        for (int i = 0; i < 9; i++) begin
            @(posedge clk); #1;
            if (i < 5) begin
                a_if.in = a_tab[i].in;
                a_if.in_valid = 1'b1;
            end else begin
                a_if.in_valid = 1'b0;
            end
            @(negedge clk);
            if (i < 5) chk("a_in_ready", 64'(a_if.in_ready), 64'd1);
            if (i >= 3 && i < 8) begin
                chk("a_out_valid", 64'(a_if.out_valid), 64'd1);
                chk("a_sum", 64'(a_if.out), 64'(a_tab[i-3].out));
                chk("a_ovf", 64'(a_if.ovf), 64'd0);
            end else begin
                chk("a_idle_valid", 64'(a_if.out_valid), 64'd0);
            end
        end

        // N=5 odd leaf: two back-to-back vectors.
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            b_if.in_valid = (i < 2);
            if (i == 0) b_if.in = {16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
            if (i == 1) b_if.in = {16'd50, 16'd40, 16'd30, 16'd20, 16'd10};
            @(negedge clk);
            if (i == 3 || i == 4) begin
                chk("b_out_valid", 64'(b_if.out_valid), 64'd1);
                chk("b_sum", 64'(b_if.out), (i == 3) ? 64'd15 : 64'd150);
            end else begin
                chk("b_idle_valid", 64'(b_if.out_valid), 64'd0);
            end
        end

        // Signed narrowing: saturating (c) and wrapping (d) side by side.
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            c_if.in_valid = (i < 7);
            d_if.in_valid = (i < 7);
            if (i < 7) begin
                c_if.in = s_tab[i].in;
                d_if.in = s_tab[i].in;
            end
            @(negedge clk);
            if (i >= 2 && i < 9) begin
                chk("c_out_valid", 64'(c_if.out_valid), 64'd1);
                chk("c_sat_out", 64'(c_if.out), 64'(s_tab[i-2].sat));
                chk("c_sat_ovf", 64'(c_if.ovf), 64'(s_tab[i-2].ovf));
                chk("d_out_valid", 64'(d_if.out_valid), 64'd1);
                chk("d_wrap_out", 64'(d_if.out), 64'(s_tab[i-2].wrap));
                chk("d_wrap_ovf", 64'(d_if.ovf), 64'(s_tab[i-2].ovf));
            end else begin
                chk("c_idle_valid", 64'(c_if.out_valid), 64'd0);
                chk("d_idle_valid", 64'(d_if.out_valid), 64'd0);
            end
        end

        // Backpressure: 6 vectors, consumer stalls in cycles 4..7.
        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            a_if.out_ready = !(cyc >= 4 && cyc <= 7);
            a_if.in_valid  = (sent < 6);
            for (int k = 0; k < 8; k++) begin
                a_if.in[16*k +: 16] = 16'((sent << 8) + k);
            end
            @(negedge clk);
            chk("bp_in_ready", 64'(a_if.in_ready),
                (cyc >= 4 && cyc <= 7) ? 64'd0 : 64'd1);
            if (cyc >= 4 && cyc <= 7) begin
                chk("bp_hold_valid", 64'(a_if.out_valid), 64'd1);
                chk("bp_hold_out", 64'(a_if.out), 64'(bp_exp[1]));
            end
            if (a_if.in_valid && a_if.in_ready) sent++;
            if (a_if.out_valid && a_if.out_ready) begin
                if (rcv < 6) chk("bp_sum", 64'(a_if.out), 64'(bp_exp[rcv]));
                else chk("bp_extra", 64'(rcv), 64'd5);
                rcv++;
            end
            if (rcv == 6) break;
        end
        chk("bp_count", 64'(rcv), 64'd6);
        @(posedge clk); #1;
        a_if.out_ready = 1'b1;
        a_if.in_valid  = 1'b0;

        // Mid-stream reset with two vectors in flight.
        @(posedge clk); #1;
        a_if.in = {8{16'd1}};
        a_if.in_valid = 1'b1;
        @(posedge clk); #1;
        a_if.in = {8{16'd2}};
        @(posedge clk); #1;
        a_if.in = {8{16'd3}};
        rst = 1'b1;
        @(negedge clk);
        chk("mr_in_ready_rst", 64'(a_if.in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        a_if.in = {8{16'd4}};
        @(negedge clk);
        chk("mr_valid", 64'(a_if.out_valid), 64'd0);
        chk("mr_out", 64'(a_if.out), 64'd0);
        chk("mr_ovf", 64'(a_if.ovf), 64'd0);
        @(posedge clk); #1;
        a_if.in_valid = 1'b0;
        for (int k = 4; k < 9; k++) begin
            @(negedge clk);
            if (k == 6) begin
                chk("mr_new_valid", 64'(a_if.out_valid), 64'd1);
                chk("mr_new_sum", 64'(a_if.out), 64'd32);
            end else begin
                chk("mr_no_stale", 64'(a_if.out_valid), 64'd0);
            end
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
